// File: rtl/clk_gen_divider.sv
// Power-of-two clock divider: a free-running counter whose top bit is registered as a
// 50%-duty slow clock, clk_gen_out = clk_gen_fsys / 2**SIZE.
module clk_gen_divider #(
  parameter int SIZE = 1
) (
  input  logic clk_gen_fsys,
  input  logic clk_gen_rst,
  output logic clk_gen_out
);

  generate
    if (SIZE < 1 || SIZE > 32) begin : g_bad_size
      $error("clk_gen_divider: SIZE must be in 1..32");
    end
  endgenerate

  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] cnt_inc;
  logic            out_q;

  assign cnt_inc = cnt + SIZE'(1);

  // The top bit of the post-increment count flips exactly when the lower bits are all
  // ones, so registering it gives the toggle without a separate compare (works for SIZE=1).
  always_ff @(posedge clk_gen_fsys or negedge clk_gen_rst) begin
    if (!clk_gen_rst) begin
      cnt   <= '0;
      out_q <= 1'b0;
    end else begin
      cnt   <= cnt_inc;
      out_q <= cnt_inc[SIZE-1];
    end
  end

  assign clk_gen_out = out_q;

endmodule

// File: tb/tb_clk_gen_divider.sv
// Directed bench for clk_gen_divider at SIZE = 1, 3 and 4 sharing one clock and reset;
// expected outputs come from an edge-count model queued per edge and checked just after it.
module tb_clk_gen_divider;

  logic clk;
  logic rst;
  logic out1, out3, out4;

  int n_total = 0;
  int n_pass  = 0;
  int n_edge  = 0;
  logic [2:0] sb_q[$];

  clk_gen_divider #(.SIZE(1)) dut1 (.clk_gen_fsys(clk), .clk_gen_rst(rst), .clk_gen_out(out1));
  clk_gen_divider #(.SIZE(3)) dut3 (.clk_gen_fsys(clk), .clk_gen_rst(rst), .clk_gen_out(out3));
  clk_gen_divider #(.SIZE(4)) dut4 (.clk_gen_fsys(clk), .clk_gen_rst(rst), .clk_gen_out(out4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic model_bit(input int n, input int s);
    int m;
    m = n % (1 << s);
    return logic'((m >> (s - 1)) & 1);
  endfunction

  // One rising edge: update the edge-count model, queue expectations, compare 1 unit later.
  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    if (rst) n_edge++;
    else     n_edge = 0;
    sb_q.push_back({model_bit(n_edge, 1), model_bit(n_edge, 3), model_bit(n_edge, 4)});
    #1;
    e = sb_q.pop_front();
    chk("size1_out", out1, e[2]);
    chk("size3_out", out3, e[1]);
    chk("size4_out", out4, e[0]);
  endtask

  task automatic async_reset();
    rst    = 1'b0;
    n_edge = 0;
    #1;
    chk("async_rst_size1", out1, 1'b0);
    chk("async_rst_size3", out3, 1'b0);
    chk("async_rst_size4", out4, 1'b0);
  endtask

  initial begin
    int hi_cnt;
    int last_rise;
    logic prev4;

    // reset applied with no clock edge yet
    async_reset();
    repeat (2) step();

    // release between edges; SIZE=1 must read 1,0,1,0
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("size1_pattern", out1, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    for (int e = 5; e <= 13; e++) begin
      step();
      if (e == 8)  chk("size3_fall_edge8", out3, 1'b0);
      if (e == 12) chk("size3_rise_edge12", out3, 1'b1);
    end
    chk("size3_high_before_rst", out3, 1'b1);

    // async reset mid-high phase, held 50 cycles with clock running
    @(negedge clk);
    #2;
    async_reset();
    repeat (50) step();

    // release again, first SIZE=3 rise back on edge 4
    @(negedge clk);
    #3;
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 3) chk("size3_low_edge3", out3, 1'b0);
      if (e == 4) chk("size3_rise_edge4", out3, 1'b1);
    end

    // release just ahead of a rising edge: that edge counts
    @(negedge clk);
    async_reset();
    repeat (3) step();
    @(negedge clk);
    #4;
    rst = 1'b1;
    step();
    chk("late_release_size1", out1, 1'b1);
    repeat (99) step();

    // long SIZE=4 run: 1000 periods, measure duty and rise spacing independently
    @(negedge clk);
    async_reset();
    step();
    @(negedge clk);
    rst       = 1'b1;
    hi_cnt    = 0;
    last_rise = 0;
    prev4     = 1'b0;
    for (int k = 1; k <= 16000; k++) begin
      step();
      if (out4 === 1'b1) hi_cnt++;
      if (out4 === 1'b1 && prev4 === 1'b0) begin
        if (last_rise > 0) chk("size4_period16", (k - last_rise) == 16, 1'b1);
        last_rise = k;
      end
      prev4 = out4;
      if (k % 16 == 0) begin
        chk("size4_duty8", hi_cnt == 8, 1'b1);
        hi_cnt = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
